// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the push-button debounce block.
// Build option: BUTTON_DEBOUNCE_EDGE_EN enables the press/release pulse registers.
package button_debounce_pkg;

  typedef enum logic {
    DB_STABLE,
    DB_PENDING
  } db_state_t;

  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/button_debounce_if.sv
// Button pad / conditioned-level bundle between the pads and the button PIO.
// Build option: BUTTON_DEBOUNCE_EDGE_EN drives btn_press / btn_release.
interface button_debounce_if #(
  parameter int NUM_BUTTONS = 4
);

  logic [NUM_BUTTONS-1:0] button_n;
  logic [NUM_BUTTONS-1:0] btn_clean_n;
  logic [NUM_BUTTONS-1:0] btn_press;
  logic [NUM_BUTTONS-1:0] btn_release;
  logic                   busy;

  modport master (
    output button_n,
    input  btn_clean_n,
    input  btn_press,
    input  btn_release,
    input  busy
  );

  modport slave (
    input  button_n,
    output btn_clean_n,
    output btn_press,
    output btn_release,
    output busy
  );

endinterface

// File: rtl/button_debounce_chan.sv
// One button channel: 2-flop synchroniser, debounce FSM, counter, edge pulses.
// Build option: BUTTON_DEBOUNCE_EDGE_EN builds the press/release registers.
module button_debounce_chan
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic osc_clk,
  input  logic reset,
  input  logic button_n,
  output logic clean_n,
  output logic press,
  output logic rel,
  output logic pend_nxt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  db_state_t        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             clean_nxt;

  // Bring the asynchronous pad level into osc_clk.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      s1 <= BTN_RELEASED;
      s2 <= BTN_RELEASED;
    end else begin
      s1 <= button_n;
      s2 <= s1;
    end
  end

  // Filter state, stability counter and accepted level.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      state   <= DB_STABLE;
      cnt     <= '0;
      clean_n <= BTN_RELEASED;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      clean_n <= clean_nxt;
    end
  end

  // Accept a new level only after it has held for the full count.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    clean_nxt = clean_n;
    unique case (state)
      DB_STABLE: begin
        if (s2 != clean_n)
          state_nxt = DB_PENDING;
      end
      DB_PENDING: begin
        if (s2 == clean_n) begin
          state_nxt = DB_STABLE;
        end else if (cnt == CNT_MAX) begin
          state_nxt = DB_STABLE;
          clean_nxt = s2;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = DB_STABLE;
    endcase
  end

  assign pend_nxt = (state_nxt == DB_PENDING);

`ifdef BUTTON_DEBOUNCE_EDGE_EN
  // One-cycle pulses aligned with the change of the accepted level.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset) begin
      press <= 1'b0;
      rel   <= 1'b0;
    end else begin
      press <= clean_n & ~clean_nxt;
      rel   <= ~clean_n & clean_nxt;
    end
  end
`else
  assign press = 1'b0;
  assign rel   = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounces NUM_BUTTONS active-low pads for the Nios II button PIO.
// Build option: BUTTON_DEBOUNCE_EDGE_EN enables btn_press / btn_release.
module button_debounce
  import button_debounce_pkg::*;
#(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              osc_clk,
  input  logic              reset,
  button_debounce_if.slave  btn
);

  logic [NUM_BUTTONS-1:0] clean;
  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] rel;
  logic [NUM_BUTTONS-1:0] pend;
  logic                   busy_q;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .osc_clk  (osc_clk),
      .reset    (reset),
      .button_n (btn.button_n[i]),
      .clean_n  (clean[i]),
      .press    (press[i]),
      .rel      (rel[i]),
      .pend_nxt (pend[i])
    );
  end

  // Any channel mid-count, registered alongside the channel states.
  always_ff @(posedge osc_clk or posedge reset) begin
    if (reset)
      busy_q <= 1'b0;
    else
      busy_q <= |pend;
  end

  assign btn.btn_clean_n = clean;
  assign btn.btn_press   = press;
  assign btn.btn_release = rel;
  assign btn.busy        = busy_q;

endmodule
